// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default link constants and
// the clocks-per-bit helper used by both the receive and transmit paths.
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ = 50000000;
  localparam int DEFAULT_BAUD     = 115200;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; the flops come
// out of reset holding RST_VAL so an idle-high line does not look like an edge.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver (8N1 by default) with valid/ready byte output, framing-error and
// overrun pulses. Define UART_RX_PARITY_EN to add a parity bit and parity_err.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int BAUD      = DEFAULT_BAUD,
  parameter int DATA_BITS = 8
`ifdef UART_RX_PARITY_EN
  , parameter logic PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy,
  output rx_state_t            state_dbg
);

  // Handshake: a byte transfers on any cycle where rx_valid && rx_ready;
  // rx_data is held stable for as long as rx_valid is high.

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 rx_s;
  logic                 rx_d;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           warm;
  logic                 armed;
  logic                 deliver_q;
  logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
  logic                 par_q;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (uart_rx),
    .q     (rx_s)
  );

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rx_d      <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      warm      <= '0;
      armed     <= 1'b0;
      deliver_q <= 1'b0;
      ferr_q    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      par_q      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_d      <= rx_s;
      deliver_q <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
`endif
      // The sync chain holds reset values for a few cycles; only arm once it
      // reflects the real line and the line has been seen high.
      if (warm != 2'd3) warm <= warm + 2'd1;

      case (state)
        IDLE: begin
          if (warm == 2'd3 && rx_s && rx_d) armed <= 1'b1;
          if (armed && rx_d && !rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bad <= ((^shreg) ^ rx_s) != PARITY_ODD;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
`ifdef UART_RX_PARITY_EN
            par_q <= par_bad;
`endif
            if (rx_s) begin
              deliver_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
              armed  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Output stage: shreg stays untouched until the next frame's first data
      // sample, so it can be loaded here one cycle after the stop sample.
      frame_err <= ferr_q;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= par_q;
`endif
      if (deliver_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receiver, 8N1 by default, for the SoC `uart_rx` pin. Completes the serial link opposite the existing transmit path.
- Synchronises the asynchronous line, detects the start bit and samples each bit at mid-bit.
- Presents received bytes on a valid/ready interface to the SoC peripheral bus.
- Flags framing errors and overruns.

Parameters:
CLK_FREQ, 50000000, core clock frequency in Hz
BAUD, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), must be >= 4
DATA_BITS, 8, data bits per frame (5..8)

Ports:
clk  input  1  core clock, single domain
reset  input  1  asynchronous, active-low reset (0 = reset)
uart_rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  received byte, LSB = first bit on the line
rx_valid  output  1  rx_data holds an unread byte
rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready
frame_err  output  1  one-cycle pulse: stop bit sampled 0
overrun  output  1  one-cycle pulse: new byte dropped because holding register full
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops reset to 1. FSM to IDLE, counters to 0.
- Reset mid-frame aborts the frame; nothing is delivered.
- Synchroniser: 2 flops, giving rx_s. Edge detect uses rx_s and a registered copy rx_d.
- FSM states: IDLE, START, DATA, PARITY (only when the parity option is compiled in), STOP.
- IDLE:
  - On rx_d=1 && rx_s=0, go to START with cnt=0.
  - A line held low out of reset does not trigger a frame.
- START:
  - Count to HALF = CLKS_PER_BIT/2 - 1, then sample rx_s.
  - rx_s=1: glitch; return to IDLE with no flags.
  - rx_s=0: go to DATA with cnt=0, bit_idx=0.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into shift register (shift right, MSB-in).
  - After DATA_BITS samples, go to STOP (or PARITY).
- STOP:
  - After CLKS_PER_BIT cycles, sample rx_s and return to IDLE immediately (mid-stop-bit). This allows back-to-back frames with 1 stop bit.
  - Sample 1: deliver byte.
  - Sample 0: frame_err=1 for one cycle, byte discarded. IDLE then requires a rising-then-falling edge before the next frame.
- Delivery, in the cycle after the stop sample:
  - If rx_valid=0, or rx_valid && rx_ready in that same cycle: rx_data takes the new byte and rx_valid=1.
  - Else: old byte kept, new byte dropped, overrun=1 for one cycle.
- Handshake:
  - rx_valid falls the cycle after rx_valid && rx_ready (unless a simultaneous delivery reloads it).
  - rx_data is stable while rx_valid=1.
- Counters:
  - cnt width is $clog2(CLKS_PER_BIT); it reloads to 0 at each sample point.
  - bit_idx width is 3.
- Latency: rx_valid rises at start edge + 2 (sync) + 1 (edge) + HALF+1 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even) and output parity_err (one-cycle pulse).
  - PARITY state samples one extra bit after the data bits.
  - Parity mismatch pulses parity_err in the delivery cycle. The byte is still delivered. frame_err is independent.
- Undefined: no PARITY state, no parity_err port; frame is DATA_BITS+2 bits.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - Function clks_per_bit(CLK_FREQ, BAUD).
  - Default baud/clock constants shared with the transmitter.
- Sub-module sync_2ff: 2-flop synchroniser with reset value parameter RST_VAL=1.
  - Reused for gpio inputs.

Test Plan (CLK_FREQ=1000000, BAUD=100000 -> 10 clks/bit, DATA_BITS=8, rx_ready=1 unless noted):
- Drive frame 0x55, stop=1 -> rx_valid for 1 cycle with rx_data=0x55, exactly at the latency formula above; frame_err=0.
- Back-to-back 0xA5 then 0x3C, no idle gap -> two deliveries, 0xA5 then 0x3C, ~100 cycles apart.
- 3-cycle low glitch on idle line -> no rx_valid, no frame_err, busy returns to 0 within ~9 cycles.
- Frame 0x81 with stop bit=0 -> frame_err pulse, rx_valid stays 0; following good 0x12 delivered after line returns high.
- rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held, overrun pulse at 0x22 delivery; raise rx_ready -> rx_valid clears, no 0x22.
- Assert reset=0 during bit 4 of a frame, release, send 0x7E -> outputs zero during reset, only 0x7E delivered; with UART_RX_PARITY_EN, even-parity error on 0x7E pulses parity_err.
